// File: rtl/comparator_stats_pkg.sv
// rtl/comparator_stats_pkg.sv - shared states, defaults and flag check for comparator_stats
package comparator_stats_pkg;

  localparam int DEF_WIDTH  = 4;
  localparam int DEF_CNT_W  = 8;
  localparam int DEF_WINDOW = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    REPORT = 2'd2
  } state_t;

  // Exactly one of {ceq, clt, cgt} must be set for a sample to be trusted
  function automatic logic is_onehot3(input logic [2:0] f);
    return (f == 3'b001) || (f == 3'b010) || (f == 3'b100);
  endfunction

endpackage

// File: rtl/comparator_stats_cmp_sat_counter.sv
// rtl/comparator_stats_cmp_sat_counter.sv - clearable up-counter that sticks at all ones
module cmp_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  // Clear has priority; increments stop once the counter is full
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/comparator_stats.sv
// rtl/comparator_stats.sv - windowed outcome tally and max/min tracker behind the comparator
module comparator_stats
  import comparator_stats_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int WINDOW = DEF_WINDOW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ceq,
  input  logic             clt,
  input  logic             cgt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] min_val,
  output logic             busy,
  output logic             done,
  input  logic             ack
);

  localparam int SC_W = $clog2(WINDOW + 1);

  state_t           state;
  logic [SC_W-1:0]  sample_cnt;
  logic             accept;
  logic             flags_ok;
  logic             clr;
  logic [WIDTH-1:0] larger;
  logic [WIDTH-1:0] smaller;

  assign accept   = in_valid && in_ready;
  assign flags_ok = is_onehot3({ceq, clt, cgt});
  // A new window opens from IDLE, or straight out of REPORT when ack and start coincide
  assign clr      = start && ((state == IDLE) || ((state == REPORT) && ack));
  assign larger   = clt ? b : a;
  assign smaller  = clt ? a : b;

  cmp_sat_counter #(.W(CNT_W)) u_eq_cnt (
    .clk(clk), .rst(rst), .clr(clr), .inc(accept && flags_ok && ceq), .q(eq_cnt)
  );
  cmp_sat_counter #(.W(CNT_W)) u_lt_cnt (
    .clk(clk), .rst(rst), .clr(clr), .inc(accept && flags_ok && clt), .q(lt_cnt)
  );
  cmp_sat_counter #(.W(CNT_W)) u_gt_cnt (
    .clk(clk), .rst(rst), .clr(clr), .inc(accept && flags_ok && cgt), .q(gt_cnt)
  );
  cmp_sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk(clk), .rst(rst), .clr(clr), .inc(accept && !flags_ok), .q(err_cnt)
  );

  // Window FSM with registered handshake outputs, sample count and max/min tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sample_cnt <= '0;
      max_val    <= '0;
      min_val    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      in_ready   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= ACCUM;
            sample_cnt <= '0;
            max_val    <= '0;
            min_val    <= '1;
            busy       <= 1'b1;
            in_ready   <= 1'b1;
          end
        end
        ACCUM: begin
          if (accept) begin
            sample_cnt <= sample_cnt + SC_W'(1);
            if (flags_ok) begin
              if (larger > max_val) max_val <= larger;
              if (smaller < min_val) min_val <= smaller;
            end
            if (sample_cnt == SC_W'(WINDOW - 1)) begin
              state    <= REPORT;
              busy     <= 1'b0;
              in_ready <= 1'b0;
              done     <= 1'b1;
            end
          end
        end
        REPORT: begin
          if (ack) begin
            done <= 1'b0;
            if (start) begin
              state      <= ACCUM;
              sample_cnt <= '0;
              max_val    <= '0;
              min_val    <= '1;
              busy       <= 1'b1;
              in_ready   <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          done     <= 1'b0;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comparator_stats.sv
// tb/tb_comparator_stats.sv - directed self-checking bench for comparator_stats
module tb_comparator_stats;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, in_valid = 1'b0, ack = 1'b0;
  logic [3:0] a = '0, b = '0;
  logic       ceq = 1'b0, clt = 1'b0, cgt = 1'b0;
  logic       in_ready, busy, done;
  logic [7:0] eq_cnt, lt_cnt, gt_cnt, err_cnt;
  logic [3:0] max_val, min_val;

  logic       s2_start = 1'b0, s2_valid = 1'b0;
  logic       s2_ready, s2_busy, s2_done;
  logic [1:0] s2_eq, s2_lt, s2_gt, s2_err;
  logic [3:0] s2_max, s2_min;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  comparator_stats #(.WIDTH(4), .CNT_W(8), .WINDOW(4)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ceq(ceq), .clt(clt), .cgt(cgt),
    .eq_cnt(eq_cnt), .lt_cnt(lt_cnt), .gt_cnt(gt_cnt), .err_cnt(err_cnt),
    .max_val(max_val), .min_val(min_val), .busy(busy), .done(done), .ack(ack)
  );

  comparator_stats #(.WIDTH(4), .CNT_W(2), .WINDOW(5)) dut2 (
    .clk(clk), .rst(rst), .start(s2_start), .in_valid(s2_valid), .in_ready(s2_ready),
    .a(4'd1), .b(4'd2), .ceq(1'b0), .clt(1'b1), .cgt(1'b0),
    .eq_cnt(s2_eq), .lt_cnt(s2_lt), .gt_cnt(s2_gt), .err_cnt(s2_err),
    .max_val(s2_max), .min_val(s2_min), .busy(s2_busy), .done(s2_done), .ack(1'b0)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // flags given as {ceq, clt, cgt}
  task automatic beat(input logic [3:0] va, input logic [3:0] vb, input logic [2:0] f);
    a = va; b = vb; {ceq, clt, cgt} = f; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0d exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0d exp 0", done); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %0d exp 0", in_ready); end
    checks++; if ({eq_cnt, lt_cnt, gt_cnt, err_cnt} !== 32'd0) begin errors++; $display("FAIL reset_cnts got %h exp 0", {eq_cnt, lt_cnt, gt_cnt, err_cnt}); end
    checks++; if ({max_val, min_val} !== 8'd0) begin errors++; $display("FAIL reset_maxmin got %h exp 0", {max_val, min_val}); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    do_start();
    checks++; if ({busy, in_ready, done} !== 3'b110) begin errors++; $display("FAIL basic_start got %b exp 110", {busy, in_ready, done}); end
    checks++; if ({max_val, min_val} !== 8'h0f) begin errors++; $display("FAIL basic_init_maxmin got %h exp 0f", {max_val, min_val}); end
    beat(4'd1, 4'd10, 3'b010);
    checks++; if ({lt_cnt, max_val, min_val} !== {8'd1, 4'd10, 4'd1}) begin errors++; $display("FAIL basic_first_beat got %h exp 01a1", {lt_cnt, max_val, min_val}); end
    beat(4'd9, 4'd9, 3'b100);
    beat(4'd12, 4'd3, 3'b001);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_early_done got %0d exp 0", done); end
    beat(4'd0, 4'd15, 3'b010);
    checks++; if ({done, in_ready, busy} !== 3'b100) begin errors++; $display("FAIL basic_done got %b exp 100", {done, in_ready, busy}); end
    checks++; if ({eq_cnt, lt_cnt, gt_cnt, err_cnt} !== {8'd1, 8'd2, 8'd1, 8'd0}) begin errors++; $display("FAIL basic_cnts got %h exp 01020100", {eq_cnt, lt_cnt, gt_cnt, err_cnt}); end
    checks++; if ({max_val, min_val} !== 8'hf0) begin errors++; $display("FAIL basic_maxmin got %h exp f0", {max_val, min_val}); end
  endtask

  task automatic test_hold_and_restart();
    for (int i = 0; i < 10; i++) begin
      a = 4'(i); b = 4'(15 - i); {ceq, clt, cgt} = 3'b010; in_valid = 1'b1; start = i[0];
      step();
      checks++; if ({done, in_ready, lt_cnt, max_val, min_val} !== {1'b1, 1'b0, 8'd2, 4'd15, 4'd0}) begin errors++; $display("FAIL hold_cycle%0d got %h exp %h", i, {done, in_ready, lt_cnt, max_val, min_val}, {1'b1, 1'b0, 8'd2, 4'd15, 4'd0}); end
    end
    in_valid = 1'b0;
    ack = 1'b1; start = 1'b1;
    step();
    ack = 1'b0; start = 1'b0;
    checks++; if ({busy, in_ready, done} !== 3'b110) begin errors++; $display("FAIL restart_flags got %b exp 110", {busy, in_ready, done}); end
    checks++; if ({eq_cnt, lt_cnt, gt_cnt, err_cnt, max_val, min_val} !== 40'h000000000f) begin errors++; $display("FAIL restart_clear got %h exp 000000000f", {eq_cnt, lt_cnt, gt_cnt, err_cnt, max_val, min_val}); end
  endtask

  task automatic test_errors();
    beat(4'd5, 4'd5, 3'b101);
    beat(4'd5, 4'd5, 3'b000);
    checks++; if ({err_cnt, max_val, min_val} !== {8'd2, 4'd0, 4'd15}) begin errors++; $display("FAIL err_no_maxmin got %h exp 020f", {err_cnt, max_val, min_val}); end
    beat(4'd2, 4'd7, 3'b010);
    beat(4'd7, 4'd2, 3'b001);
    checks++; if ({done, eq_cnt, lt_cnt, gt_cnt, err_cnt} !== {1'b1, 8'd0, 8'd1, 8'd1, 8'd2}) begin errors++; $display("FAIL err_cnts got %h exp %h", {done, eq_cnt, lt_cnt, gt_cnt, err_cnt}, {1'b1, 8'd0, 8'd1, 8'd1, 8'd2}); end
    checks++; if ({max_val, min_val} !== 8'h72) begin errors++; $display("FAIL err_maxmin got %h exp 72", {max_val, min_val}); end
    ack = 1'b1;
    step();
    ack = 1'b0;
    step();
    checks++; if ({done, busy, in_ready} !== 3'b000) begin errors++; $display("FAIL ack_to_idle got %b exp 000", {done, busy, in_ready}); end
    checks++; if ({lt_cnt, err_cnt, max_val, min_val} !== {8'd1, 8'd2, 4'd7, 4'd2}) begin errors++; $display("FAIL idle_readable got %h exp 010272", {lt_cnt, err_cnt, max_val, min_val}); end
  endtask

  task automatic test_saturate();
    s2_start = 1'b1;
    step();
    s2_start = 1'b0;
    s2_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      if (i >= 3) begin
        checks++; if (s2_lt !== 2'd3) begin errors++; $display("FAIL sat_beat%0d got %0d exp 3", i, s2_lt); end
      end
    end
    s2_valid = 1'b0;
    checks++; if ({s2_done, s2_ready} !== 2'b10) begin errors++; $display("FAIL sat_done got %b exp 10", {s2_done, s2_ready}); end
  endtask

  task automatic test_reset_mid();
    do_start();
    beat(4'd3, 4'd8, 3'b010);
    beat(4'd6, 4'd6, 3'b100);
    #2 rst = 1'b1;
    #1;
    checks++; if ({busy, in_ready, done, eq_cnt, lt_cnt, max_val, min_val} !== 27'd0) begin errors++; $display("FAIL async_reset got %h exp 0", {busy, in_ready, done, eq_cnt, lt_cnt, max_val, min_val}); end
    step();
    rst = 1'b0;
    step();
    checks++; if ({busy, in_ready} !== 2'b00) begin errors++; $display("FAIL reset_idle got %b exp 00", {busy, in_ready}); end
    do_start();
    beat(4'd4, 4'd9, 3'b010);
    beat(4'd8, 4'd1, 3'b001);
    start = 1'b1;
    beat(4'd2, 4'd2, 3'b100);
    start = 1'b0;
    checks++; if ({eq_cnt, lt_cnt, gt_cnt, done} !== {8'd1, 8'd1, 8'd1, 1'b0}) begin errors++; $display("FAIL fresh_start_ignored got %h exp %h", {eq_cnt, lt_cnt, gt_cnt, done}, {8'd1, 8'd1, 8'd1, 1'b0}); end
    beat(4'd11, 4'd13, 3'b010);
    checks++; if ({done, lt_cnt, max_val, min_val} !== {1'b1, 8'd2, 4'd13, 4'd1}) begin errors++; $display("FAIL fresh_window got %h exp %h", {done, lt_cnt, max_val, min_val}, {1'b1, 8'd2, 4'd13, 4'd1}); end
    ack = 1'b1;
    step();
    ack = 1'b0;
  endtask

  task automatic test_toggle();
    do_start();
    a = 4'd3; b = 4'd4; {ceq, clt, cgt} = 3'b010;
    for (int i = 0; i < 7; i++) begin
      in_valid = ~i[0];
      step();
      if (i == 5) begin
        checks++; if ({done, lt_cnt} !== {1'b0, 8'd3}) begin errors++; $display("FAIL toggle_mid got %h exp 003", {done, lt_cnt}); end
      end
    end
    checks++; if ({done, lt_cnt} !== {1'b1, 8'd4}) begin errors++; $display("FAIL toggle_done got %h exp 104", {done, lt_cnt}); end
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (lt_cnt !== 8'd4) begin errors++; $display("FAIL no_extra_sample got %0d exp 4", lt_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold_and_restart();
    test_errors();
    test_saturate();
    test_reset_mid();
    test_toggle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
